// File: rtl/toaplan2_cen_gen_pkg.sv
// toaplan2_pkg: shared channel map and 48 MHz clock-enable ratio constants
package toaplan2_pkg;
    localparam int NCH_DEF     = 4;
    localparam int W_DEF       = 16;
    localparam int CH_PIXEL    = 0;
    localparam int CH_OKI      = 1;
    localparam int CH_YM       = 2;
    localparam int CH_YM_HALF  = 3;
    localparam int PIXEL_NUM   = 9;
    localparam int PIXEL_DEN   = 64;
    localparam int OKI_NUM     = 1;
    localparam int OKI_DEN     = 12;
    localparam int YM_NUM      = 9;
    localparam int YM_DEN      = 128;
    localparam int YM_HALF_NUM = 9;
    localparam int YM_HALF_DEN = 256;
endpackage

// File: rtl/toaplan2_cen_chan.sv
// toaplan2_cen_chan: one fractional clock-enable channel with CEN/CENB phase split
module toaplan2_cen_chan
    import toaplan2_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic         i_pause,
    input  logic [W-1:0] i_num,
    input  logic [W-1:0] i_den,
    output logic         o_cen,
    output logic         o_cenb,
    output logic         o_cfg_err
);
    logic [W-1:0] r_num, r_den;
    logic [W+1:0] r_acc;
    logic         r_phase, r_cen, r_cenb, r_err;
    logic [W+1:0] w_sum;
    logic         w_tick, w_bad;

    // next accumulator value, tick decision and validity of the incoming config
    always_comb begin
        w_sum  = r_acc + {1'b0, r_num, 1'b0};
        w_tick = w_sum >= {2'b00, r_den};
        w_bad  = (i_den == '0) || ({i_num, 1'b0} > {1'b0, i_den});
    end

    // shadow capture, accumulator stepping and registered pulse outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_num   <= '0;
            r_den   <= W'(1);
            r_acc   <= '0;
            r_phase <= 1'b0;
            r_cen   <= 1'b0;
            r_cenb  <= 1'b0;
            r_err   <= 1'b0;
        end else if (i_load) begin
            r_num   <= i_num;
            r_den   <= i_den;
            r_acc   <= '0;
            r_phase <= 1'b0;
            r_cen   <= 1'b0;
            r_cenb  <= 1'b0;
            r_err   <= w_bad;
        end else if (r_err || i_pause) begin
            r_cen   <= 1'b0;
            r_cenb  <= 1'b0;
        end else begin
            r_acc   <= w_tick ? w_sum - {2'b00, r_den} : w_sum;
            r_phase <= r_phase ^ w_tick;
            r_cen   <= w_tick & ~r_phase;
            r_cenb  <= w_tick & r_phase;
        end
    end

    assign o_cen     = r_cen;
    assign o_cenb    = r_cenb;
    assign o_cfg_err = r_err;
endmodule

// File: rtl/toaplan2_cen_gen.sv
// toaplan2_cen_gen: bank of independent fractional clock-enable channels
module toaplan2_cen_gen
    import toaplan2_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NCH*W-1:0] i_num,
    input  logic [NCH*W-1:0] i_den,
    input  logic             i_cfg_load,
    input  logic [NCH-1:0]   i_pause,
    output logic [NCH-1:0]   o_cen,
    output logic [NCH-1:0]   o_cenb,
    output logic [NCH-1:0]   o_cfg_err
);
    for (genvar k = 0; k < NCH; k++) begin : g_chan
        toaplan2_cen_chan #(.W(W)) u_chan (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_load    (i_cfg_load),
            .i_pause   (i_pause[k]),
            .i_num     (i_num[k*W +: W]),
            .i_den     (i_den[k*W +: W]),
            .o_cen     (o_cen[k]),
            .o_cenb    (o_cenb[k]),
            .o_cfg_err (o_cfg_err[k])
        );
    end
endmodule

// File: doc/toaplan2_cen_gen.md
TOAPLAN2_CEN_GEN -- requirements
Module: toaplan2_cen_gen

Interface
REQ-001 Parameter NCH, default 4: number of independent clock-enable channels (1..8).
REQ-002 Parameter W, default 16: width of each channel's numerator and denominator.
REQ-003 CLK  in  1  single system clock; all logic is synchronous to its rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 NUM  in  NCH*W  packed per-channel numerators; channel k occupies bits [k*W +: W].
REQ-006 DEN  in  NCH*W  packed per-channel denominators, same packing as NUM.
REQ-007 CFG_LOAD  in  1  one-cycle strobe that captures NUM and DEN into the shadow registers of all channels.
REQ-008 PAUSE  in  NCH  per-channel freeze mask.
REQ-009 CEN  out  NCH  per-channel clock-enable pulse, one CLK wide.
REQ-010 CENB  out  NCH  per-channel complementary pulse, midway between consecutive CEN pulses.
REQ-011 CFG_ERR  out  NCH  per-channel flag: the captured configuration is invalid.

Function
REQ-012 Each channel SHALL run an internal tick at the rate 2*NUM/DEN of CLK, using the captured NUM/DEN values only.
REQ-013 The accumulator SHALL be W+2 bits wide with no overflow, and each cycle SHALL update as follows:
- s = acc + 2*NUM;
- if s >= DEN: acc <= s - DEN and a tick occurs;
- else: acc <= s.
REQ-014 The accumulator value SHALL always remain below DEN.
REQ-015 Ticks SHALL alternate between CEN and CENB under a per-channel phase bit, starting with CEN after reset or load.
REQ-016 Output latency: CEN/CENB SHALL assert on the CLK edge after the cycle in which the tick is computed, giving a registered one-cycle latency.
REQ-017 Over any DEN consecutive active cycles, a channel SHALL emit exactly NUM CEN pulses and NUM CENB pulses.
REQ-018 CEN and CENB of the same channel SHALL never assert in the same cycle.
REQ-019 A channel SHALL be invalid when DEN==0 or 2*NUM > DEN.
- On capture of an invalid configuration, CFG_ERR[k] SHALL be set, the channel SHALL hold its accumulator at 0, and its CEN/CENB SHALL stay 0.
REQ-020 When NUM==0 and DEN is nonzero, the channel SHALL be valid and SHALL emit no pulses.
REQ-021 When 2*NUM==DEN, a tick SHALL occur every cycle, so CEN and CENB alternate every cycle.
REQ-022 On CFG_LOAD, all channels SHALL:
- capture NUM/DEN;
- clear the accumulator to 0;
- reset the phase bit to CEN;
- recompute CFG_ERR;
- drive CEN/CENB to 0 in the following cycle.
REQ-023 Counting under the new configuration SHALL start in the cycle after CFG_LOAD.
REQ-024 While PAUSE[k] is high:
- the accumulator and phase of channel k SHALL hold;
- CEN[k]/CENB[k] SHALL be 0;
- on deassertion, channel k SHALL resume exactly where it stopped, with no burst or lost pulse.
REQ-025 If CFG_LOAD and PAUSE[k] are asserted in the same cycle, the load SHALL take effect (capture and clear) and channel k SHALL then remain frozen at acc=0 until PAUSE[k] drops.
REQ-026 Changes to NUM/DEN without CFG_LOAD SHALL have no effect.
REQ-027 Channels SHALL be fully independent; no channel's state may affect another's.

Reset
REQ-028 While RESET is high, every channel SHALL be reset:
- shadow NUM = 0 and shadow DEN = 1 (valid, silent);
- acc = 0, phase = CEN;
- CEN = 0, CENB = 0, CFG_ERR = 0.
REQ-029 RESET SHALL take priority over CFG_LOAD and PAUSE in the same cycle.
REQ-030 A reset asserted mid-operation SHALL take effect on the next edge; the first CEN after reset requires a subsequent CFG_LOAD.

Structure
REQ-031 A shared package toaplan2_pkg SHALL hold:
- the default NCH and W;
- the channel-index localparams CH_PIXEL, CH_OKI, CH_YM, CH_YM_HALF;
- the standard 48 MHz ratio constants, e.g. pixel 6.75 MHz = 9/64, OKI 4 MHz = 1/12, YM2151 3.375 MHz = 9/128.
REQ-032 One sub-module, toaplan2_cen_chan, SHALL implement a single channel (shadow registers, accumulator, phase, error flag).
- The top SHALL instantiate it NCH times in a generate loop.

Verification
REQ-033 The bench SHALL cover each of the following directed scenarios:
- NUM=1, DEN=8 loaded -> CEN on cycles 8, 16, 24… after the load and CENB 4 cycles after each CEN; no overlap.
- Channel 0 NUM=9, DEN=64 -> exactly 9 CEN and 9 CENB in every 64-cycle window over 6400 cycles; channel 1 NUM=1, DEN=12 unaffected (533 CEN pulses in 6400 cycles).
- PAUSE[0] held 37 cycles mid-stream -> no pulses during the pause; the pulse sequence after release equals the unpaused sequence shifted by 37 cycles.
- Load NUM=5, DEN=8 on ch2 and DEN=0 on ch3 -> CFG_ERR=4'b1100, CEN/CENB of ch2/ch3 stay 0; a later valid load clears CFG_ERR.
- 2*NUM==DEN (NUM=4, DEN=8) -> CEN and CENB alternate every cycle starting with CEN one cycle after the load.
- RESET pulsed during active counting, together with CFG_LOAD -> all outputs 0 and no pulses until a fresh CFG_LOAD.
